// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS core's bus bridges.
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StDone
  } bridge_state_e;

  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;
  localparam logic [3:0]  BE_WORD      = 4'hF;

endpackage

// File: rtl/mips_data_bus_bridge_if.sv
// Waitrequest-style shared memory bus between a bridge (master) and memory (slave).
interface mips_data_bus_bridge_if;

  logic [31:0] bus_address;
  logic        bus_read;
  logic        bus_write;
  logic [3:0]  bus_byteenable;
  logic [31:0] bus_writedata;
  logic [31:0] bus_readdata;
  logic        bus_waitrequest;

  modport master (
    output bus_address,
    output bus_read,
    output bus_write,
    output bus_byteenable,
    output bus_writedata,
    input  bus_readdata,
    input  bus_waitrequest
  );

  modport slave (
    input  bus_address,
    input  bus_read,
    input  bus_write,
    input  bus_byteenable,
    input  bus_writedata,
    output bus_readdata,
    output bus_waitrequest
  );

endinterface

// File: rtl/mips_wait_timer.sv
// Wait-cycle counter with synchronous clear; expired_o flags the last allowed count.
module mips_wait_timer #(
  parameter int unsigned Limit = 256,
  parameter int unsigned CntW  = 9
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign expired_o = (cnt_q == CntW'(Limit - 1));

endmodule

// File: rtl/mips_data_bus_bridge.sv
// Turns the core's level-style LW/SW requests into one registered waitrequest bus
// transaction, stalling the core until it completes, aborts or is rejected.
module mips_data_bus_bridge
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned CNT_W          = 9
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cpu_read,
  input  logic                          cpu_write,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wdata,
  output logic [31:0]                   cpu_rdata,
  output logic                          cpu_stall,
  mips_data_bus_bridge_if.master        bus_io,
  output logic                          err_misaligned,
  output logic                          err_timeout
);

  bridge_state_e state_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          rd_q, wr_q, err_mis_q, err_to_q;
  logic [3:0]    be_q;
  logic          req, expired;

  assign req = cpu_read | cpu_write;

  mips_wait_timer #(
    .Limit (TIMEOUT_CYCLES),
    .CntW  (CNT_W)
  ) u_wait_timer (
    .clk_i     (clk),
    .rst_i     (reset),
    .clr_i     (state_q != StIssue),
    .en_i      ((state_q == StIssue) && bus_io.bus_waitrequest),
    .expired_o (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      be_q      <= '0;
      err_mis_q <= 1'b0;
      err_to_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req) begin
            if (cpu_addr[1:0] != 2'b00) begin
              err_mis_q <= 1'b1;
              rdata_q   <= '0;
              state_q   <= StDone;
            end else begin
              // Write wins when both strobes are high.
              addr_q  <= cpu_addr;
              wdata_q <= cpu_write ? cpu_wdata : '0;
              wr_q    <= cpu_write;
              rd_q    <= ~cpu_write;
              be_q    <= BE_WORD;
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          if (!bus_io.bus_waitrequest) begin
            rdata_q <= rd_q ? bus_io.bus_readdata : '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            be_q    <= '0;
            state_q <= StDone;
          end else if (expired) begin
            rdata_q  <= TIMEOUT_FILL;
            err_to_q <= 1'b1;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            be_q     <= '0;
            state_q  <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cpu_stall = ((state_q == StIdle) && req) || (state_q == StIssue);
  assign cpu_rdata = rdata_q;

  assign bus_io.bus_address    = addr_q;
  assign bus_io.bus_read       = rd_q;
  assign bus_io.bus_write      = wr_q;
  assign bus_io.bus_byteenable = be_q;
  assign bus_io.bus_writedata  = wdata_q;

  assign err_misaligned = err_mis_q;
  assign err_timeout    = err_to_q;

endmodule

// File: tb/tb_mips_data_bus_bridge.sv
// Scoreboard bench: requests push expected results; a negedge monitor checks each completion.
module tb_mips_data_bus_bridge;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_read = 1'b0, cpu_write = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall, err_misaligned, err_timeout;

  mips_data_bus_bridge_if bus ();

  mips_data_bus_bridge #(
    .TIMEOUT_CYCLES (4),
    .CNT_W          (3)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .cpu_read       (cpu_read),
    .cpu_write      (cpu_write),
    .cpu_addr       (cpu_addr),
    .cpu_wdata      (cpu_wdata),
    .cpu_rdata      (cpu_rdata),
    .cpu_stall      (cpu_stall),
    .bus_io         (bus.master),
    .err_misaligned (err_misaligned),
    .err_timeout    (err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          chk_rdata;
    bit          mis;
    bit          to;
    int          stall;
    int          rd;
    int          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   wait_cnt = 0;
  bit   mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Slave: inserts wait_cnt waitrequest cycles into each transaction.
  initial begin
    bus.bus_waitrequest = 1'b0;
    bus.bus_readdata    = '0;
  end
  always @(negedge clk) begin
    #1;
    if (bus.bus_read || bus.bus_write) begin
      if (wait_cnt > 0) begin
        bus.bus_waitrequest = 1'b1;
        wait_cnt--;
      end else begin
        bus.bus_waitrequest = 1'b0;
      end
    end else begin
      bus.bus_waitrequest = 1'b0;
    end
  end

  // Monitor
  int st_n = 0, rd_n = 0, wr_n = 0;
  bit hold_bad = 1'b0, prev_stall = 1'b0;
  always @(negedge clk) begin
    if (!mon_en) begin
      st_n = 0; rd_n = 0; wr_n = 0; hold_bad = 1'b0; prev_stall = 1'b0;
    end else begin
      if (cpu_stall) st_n++;
      if (bus.bus_read) rd_n++;
      if (bus.bus_write) wr_n++;
      if (bus.bus_read || bus.bus_write) begin
        if (q.size() == 0 || bus.bus_address !== q[0].addr ||
            bus.bus_writedata !== q[0].wdata || bus.bus_byteenable !== BE_WORD)
          hold_bad = 1'b1;
      end else if (bus.bus_byteenable !== 4'h0) begin
        hold_bad = 1'b1;
      end
      if (prev_stall && !cpu_stall) begin
        if (q.size() == 0) begin
          chk("unexpected_completion", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("stall_cycles", st_n, e.stall);
          chk("read_cycles", rd_n, e.rd);
          chk("write_cycles", wr_n, e.wr);
          chk("bus_hold", {31'd0, hold_bad}, 32'd0);
          chk("err_misaligned", {31'd0, err_misaligned}, {31'd0, e.mis});
          chk("err_timeout", {31'd0, err_timeout}, {31'd0, e.to});
          if (e.chk_rdata) chk("cpu_rdata", cpu_rdata, e.rdata);
        end
        st_n = 0; rd_n = 0; wr_n = 0; hold_bad = 1'b0;
      end
      prev_stall = cpu_stall;
    end
  end

  task automatic run_req(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int waits,
                         input logic [31:0] rdata_bus, input exp_t e);
    int n;
    q.push_back(e);
    @(posedge clk); #1;
    cpu_read = rd; cpu_write = wr; cpu_addr = addr; cpu_wdata = wdata;
    bus.bus_readdata = rdata_bus;
    wait_cnt = waits;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (cpu_stall && n < 50);
    if (n >= 50) chk("completion_bound", 32'd0, 32'd1);
    @(posedge clk); #1;
    cpu_read = 1'b0; cpu_write = 1'b0;
    // Changing address/data afterwards must not matter.
    cpu_addr = 32'hFFFF_FFFF; cpu_wdata = 32'h5555_5555;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_bus_address"}, bus.bus_address, 32'd0);
    chk({tag, "_bus_strobes"}, {30'd0, bus.bus_read, bus.bus_write}, 32'd0);
    chk({tag, "_bus_byteenable"}, {28'd0, bus.bus_byteenable}, 32'd0);
    chk({tag, "_bus_writedata"}, bus.bus_writedata, 32'd0);
    chk({tag, "_cpu_rdata"}, cpu_rdata, 32'd0);
    chk({tag, "_cpu_stall"}, {31'd0, cpu_stall}, 32'd0);
    chk({tag, "_errs"}, {30'd0, err_misaligned, err_timeout}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk_idle_outputs("reset");
    mon_en = 1'b1;

    // Aligned LW, zero wait
    run_req(1, 0, 32'h0000_1000, 32'h0, 0, 32'h1234_5678,
            '{32'h1234_5678, 1, 0, 0, 2, 1, 0, 32'h0000_1000, 32'h0});
    // SW with 3 waits: completion lands on the timeout edge and must win
    run_req(0, 1, 32'h0000_0040, 32'hA5A5_0001, 3, 32'h0,
            '{32'h0, 0, 0, 0, 5, 0, 4, 32'h0000_0040, 32'hA5A5_0001});
    // Misaligned LW
    run_req(1, 0, 32'h0000_0003, 32'h0, 0, 32'h7777_7777,
            '{32'h0, 1, 1, 0, 1, 0, 0, 32'h0, 32'h0});
    // Stuck waitrequest: abort after 4 ISSUE cycles
    run_req(1, 0, 32'h0000_0200, 32'h0, 1000, 32'h1111_2222,
            '{32'hDEAD_BEEF, 1, 1, 1, 5, 4, 0, 32'h0000_0200, 32'h0});
    // Both strobes: write wins
    run_req(1, 1, 32'h0000_0100, 32'hCAFE_0002, 0, 32'h3333_4444,
            '{32'h0, 0, 1, 1, 2, 0, 1, 32'h0000_0100, 32'hCAFE_0002});

    // Reset during the 2nd waitrequest cycle
    mon_en = 1'b0;
    @(posedge clk); #1;
    cpu_write = 1'b1; cpu_addr = 32'h0000_0080; cpu_wdata = 32'h0000_0011;
    wait_cnt = 100;
    @(posedge clk); #1;
    chk("pre_reset_write", {31'd0, bus.bus_write}, 32'd1);
    @(posedge clk); #1;
    reset = 1'b1; cpu_write = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    chk_idle_outputs("midreset");
    mon_en = 1'b1;

    // Normal aligned LW after reset, one wait cycle
    run_req(1, 0, 32'h0000_2000, 32'h0, 1, 32'h0BAD_F00D,
            '{32'h0BAD_F00D, 1, 0, 0, 3, 2, 0, 32'h0000_2000, 32'h0});

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
